// File: rtl/mul_norm_shift_pipe.sv
// Normalisation shift-amount unit for the FP multiplier.
// Derives the mantissa left/right shift, the adjusted exponent and the
// tiny/sat/zero/ovf flags from the pre-normalisation exponent and the
// product leading-zero count, then carries the result through STAGES
// elastic valid/ready register slots.
module mul_norm_shift_pipe #(
  parameter int EXPO_W  = 8,
  parameter int MANT_W  = 23,
  parameter int ZERO_D  = 6,
  parameter int SAT_MAX = 2*MANT_W+1,
  parameter int STAGES  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [EXPO_W+1:0]   expo_1,
  input  logic [ZERO_D:0]     lzc,
  input  logic                ftz,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ZERO_D:0]     l_shift,
  output logic [ZERO_D:0]     r_shift,
  output logic [EXPO_W+1:0]   expo_out,
  output logic                tiny,
  output logic                sat,
  output logic                zero,
  output logic                ovf
);

  localparam int EW = EXPO_W + 2;
  localparam int SW = ZERO_D + 1;

  localparam logic signed [EW-1:0] ONE    = EW'(1);
  localparam logic signed [EW-1:0] OVF_TH = EW'((1 << EXPO_W) - 1);
  localparam logic [SW-1:0]        SAT_SW = SW'(SAT_MAX);
  localparam logic [EW:0]          SAT_RW = (EW+1)'(SAT_MAX);

  typedef struct packed {
    logic [SW-1:0] l_shift;
    logic [SW-1:0] r_shift;
    logic [EW-1:0] expo;
    logic          tiny;
    logic          sat;
    logic          zero;
    logic          ovf;
  } payload_t;

  logic signed [EW-1:0] e;
  logic signed [EW-1:0] lzc_s;
  logic signed [EW-1:0] e_m1;
  logic signed [EW-1:0] e_diff;
  logic signed [EW-1:0] expo_res;
  logic [EW:0]          raw;
  payload_t             res;

  logic [STAGES-1:0]    vld;
  payload_t             pl [STAGES];
  logic [STAGES-1:0]    rdy;

  // Combinational shift/exponent/flag computation for the incoming beat.
  // raw is one bit wider than the exponent so 1 - e cannot wrap for the
  // most negative exponent before the saturation compare.
  always_comb begin
    e        = expo_1;
    lzc_s    = signed'(EW'(lzc));
    e_m1     = e - ONE;
    e_diff   = e - lzc_s;
    raw      = (EW+1)'(1) - {e[EW-1], e};
    expo_res = '0;
    res      = '0;
    if (e >= ONE) begin
      res.l_shift = (lzc_s < e_m1) ? lzc : e_m1[SW-1:0];
      expo_res    = e - signed'(EW'(res.l_shift));
      res.tiny    = (e_diff < ONE);
    end else if (!ftz) begin
      res.sat     = (raw > SAT_RW);
      res.r_shift = res.sat ? SAT_SW : raw[SW-1:0];
      expo_res    = ONE;
      res.tiny    = 1'b1;
    end else begin
      res.r_shift = SAT_SW;
      expo_res    = '0;
      res.zero    = 1'b1;
      res.tiny    = 1'b1;
    end
    res.expo = expo_res;
    res.ovf  = (expo_res >= OVF_TH);
    if (res.ovf) begin
      res.tiny = 1'b0;
      res.sat  = 1'b0;
      res.zero = 1'b0;
    end
  end

  // Slot k may load when downstream can take a beat or any slot from k to
  // the output is empty; flattened to avoid a combinational chain on rdy.
  always_comb begin
    rdy = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      rdy[k] = out_ready;
      for (int unsigned j = k; j < STAGES; j++) begin
        if (!vld[j]) rdy[k] = 1'b1;
      end
    end
  end

  // Elastic slot registers; payload only moves with a valid beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int unsigned k = 0; k < STAGES; k++) pl[k] <= '0;
    end else begin
      if (rdy[0]) begin
        vld[0] <= in_valid;
        if (in_valid) pl[0] <= res;
      end
      for (int unsigned k = 1; k < STAGES; k++) begin
        if (rdy[k]) begin
          vld[k] <= vld[k-1];
          if (vld[k-1]) pl[k] <= pl[k-1];
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld[STAGES-1];
  assign l_shift   = pl[STAGES-1].l_shift;
  assign r_shift   = pl[STAGES-1].r_shift;
  assign expo_out  = pl[STAGES-1].expo;
  assign tiny      = pl[STAGES-1].tiny;
  assign sat       = pl[STAGES-1].sat;
  assign zero      = pl[STAGES-1].zero;
  assign ovf       = pl[STAGES-1].ovf;

endmodule

// File: tb/tb_mul_norm_shift_pipe.sv
// Bench for mul_norm_shift_pipe at default parameters: directed vectors,
// back-to-back streaming, backpressure with mid-stall reset, and random
// valid/ready traffic checked against an arithmetic reference model.
module tb_mul_norm_shift_pipe;

  localparam int STAGES = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] expo_1;
  logic [6:0] lzc;
  logic       ftz;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] l_shift;
  logic [6:0] r_shift;
  logic [9:0] expo_out;
  logic       tiny;
  logic       sat;
  logic       zero;
  logic       ovf;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [6:0] l;
    logic [6:0] r;
    logic [9:0] eo;
    logic       tiny;
    logic       sat;
    logic       zero;
    logic       ovf;
  } res_t;

  mul_norm_shift_pipe #(
    .EXPO_W (8),
    .MANT_W (23),
    .ZERO_D (6),
    .SAT_MAX(47),
    .STAGES (STAGES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .expo_1   (expo_1),
    .lzc      (lzc),
    .ftz      (ftz),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .l_shift  (l_shift),
    .r_shift  (r_shift),
    .expo_out (expo_out),
    .tiny     (tiny),
    .sat      (sat),
    .zero     (zero),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: shift rules evaluated with plain integer arithmetic.
  function automatic res_t model(int e, int lz, bit f);
    int l, r, eo, raw;
    bit t, s, z, o;
    l = 0; r = 0; eo = 0; t = 0; s = 0; z = 0;
    if (e >= 1) begin
      l  = (lz < e - 1) ? lz : e - 1;
      eo = e - l;
      t  = (e - lz < 1);
    end else if (!f) begin
      raw = 1 - e;
      r   = (raw > 47) ? 47 : raw;
      s   = (raw > 47);
      eo  = 1;
      t   = 1;
    end else begin
      r  = 47;
      z  = 1;
      t  = 1;
    end
    o = (eo >= 255);
    if (o) begin
      t = 0; s = 0; z = 0;
    end
    return {7'(l), 7'(r), 10'(eo), t, s, z, o};
  endfunction

  function automatic res_t observed();
    return {l_shift, r_shift, expo_out, tiny, sat, zero, ovf};
  endfunction

  task automatic drive_random();
    expo_1 = 10'($urandom_range(0, 1023));
    lzc    = 7'($urandom_range(0, 127));
    ftz    = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    expo_1 = '0; lzc = '0; ftz = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    tests_run++;
    if (observed() !== '0) begin
      tests_failed++;
      $display("FAIL reset_payload: got %h expected 0", observed());
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    localparam int N = 13;
    int   t_e  [N] = '{100, 10, 30, -5, -100, -46, 0, 5, 300, 254, -511, 1, -45};
    int   t_lz [N] = '{0, 20, 5, 0, 0, 0, 0, 2, 0, 0, 0, 5, 3};
    int   t_f  [N] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
    int   t_l  [N] = '{0, 9, 5, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0};
    int   t_r  [N] = '{0, 0, 0, 6, 47, 47, 47, 0, 0, 0, 47, 0, 46};
    int   t_eo [N] = '{100, 1, 25, 1, 1, 1, 0, 3, 300, 254, 1, 1, 1};
    // flags packed as tiny=8, sat=4, zero=2, ovf=1
    int   t_fl [N] = '{0, 8, 0, 8, 12, 8, 10, 0, 1, 0, 12, 8, 8};
    res_t ex;
    int   lat;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      expo_1    = 10'(t_e[i]);
      lzc       = 7'(t_lz[i]);
      ftz       = t_f[i][0];
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL dir_in_ready[%0d]: got %b expected 1", i, in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(negedge clk);
        #1;
        lat++;
      end
      tests_run++;
      if (lat !== STAGES) begin
        tests_failed++;
        $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, STAGES);
      end
      ex = {7'(t_l[i]), 7'(t_r[i]), 10'(t_eo[i]), t_fl[i][3:0]};
      tests_run++;
      if (observed() !== ex) begin
        tests_failed++;
        $display("FAIL dir_result[%0d] e=%0d lzc=%0d ftz=%0d: got %h expected %h",
                 i, t_e[i], t_lz[i], t_f[i], observed(), ex);
      end
      @(posedge clk);
    end
  endtask

  task automatic test_back_to_back();
    res_t q[$];
    res_t ex;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (cyc < 10);
      drive_random();
      #1;
      if (cyc >= STAGES && cyc < 10 + STAGES) begin
        tests_run++;
        if (out_valid !== 1'b1 || q.size() == 0) begin
          tests_failed++;
          $display("FAIL b2b_bubble[%0d]: got out_valid=%b expected 1", cyc, out_valid);
        end else begin
          ex = q.pop_front();
          if (observed() !== ex) begin
            tests_failed++;
            $display("FAIL b2b_result[%0d]: got %h expected %h", cyc, observed(), ex);
          end
        end
      end else begin
        tests_run++;
        if (out_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b_idle[%0d]: got out_valid=%b expected 0", cyc, out_valid);
        end
      end
      if (cyc < 10) begin
        tests_run++;
        if (in_ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_in_ready[%0d]: got %b expected 1", cyc, in_ready);
        end
        q.push_back(model(int'($signed(expo_1)), int'(lzc), ftz));
      end
      @(posedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    res_t ea, eb, ec;
    ea = model(100, 0, 1'b0);
    eb = model(-5, 0, 1'b0);
    ec = model(30, 5, 1'b0);

    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    expo_1 = 10'd100; lzc = 7'd0; ftz = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_accept_a: got in_ready=%b expected 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    expo_1 = 10'(-5); lzc = 7'd0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_accept_b: got in_ready=%b expected 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    expo_1 = 10'd30; lzc = 7'd5;
    #1;
    for (int h = 0; h < 4; h++) begin
      tests_run++;
      if (in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_full[%0d]: got in_ready=%b expected 0", h, in_ready);
      end
      tests_run++;
      if (out_valid !== 1'b1 || observed() !== ea) begin
        tests_failed++;
        $display("FAIL bp_hold_a[%0d]: got valid=%b %h expected valid=1 %h",
                 h, out_valid, observed(), ea);
      end
      @(posedge clk);
      @(negedge clk);
      #1;
    end

    out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || observed() !== ea) begin
      tests_failed++;
      $display("FAIL bp_release_a: got rdy=%b valid=%b %h expected rdy=1 valid=1 %h",
               in_ready, out_valid, observed(), ea);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || observed() !== eb) begin
      tests_failed++;
      $display("FAIL bp_order_b: got valid=%b %h expected valid=1 %h", out_valid, observed(), eb);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || observed() !== ec) begin
      tests_failed++;
      $display("FAIL bp_order_c: got valid=%b %h expected valid=1 %h", out_valid, observed(), ec);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_drained: got out_valid=%b expected 0", out_valid);
    end

    // Fill the pipe under stall, then reset mid-cycle.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int b = 0; b < 2; b++) begin
      drive_random();
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || observed() !== '0) begin
      tests_failed++;
      $display("FAIL bp_mid_reset: got valid=%b rdy=%b %h expected valid=0 rdy=1 0",
               out_valid, in_ready, observed());
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_stale[%0d]: got out_valid=%b expected 0", c, out_valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    res_t q[$];
    int   budget;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      drive_random();
      #1;
      tests_run++;
      if (in_ready !== (out_ready || (q.size() < STAGES))) begin
        tests_failed++;
        $display("FAIL rand_in_ready[%0d]: got %b expected %b (in flight %0d)",
                 cyc, in_ready, (out_ready || (q.size() < STAGES)), q.size());
      end
      if (out_valid) begin
        tests_run++;
        if (q.size() == 0) begin
          tests_failed++;
          $display("FAIL rand_spurious[%0d]: got out_valid=1 expected 0", cyc);
        end else begin
          if (observed() !== q[0]) begin
            tests_failed++;
            $display("FAIL rand_result[%0d]: got %h expected %h", cyc, observed(), q[0]);
          end
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready)
        q.push_back(model(int'($signed(expo_1)), int'(lzc), ftz));
      @(posedge clk);
    end

    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    budget = 0;
    while (q.size() != 0 && budget < 20) begin
      #1;
      if (out_valid) begin
        tests_run++;
        if (observed() !== q[0]) begin
          tests_failed++;
          $display("FAIL rand_drain: got %h expected %h", observed(), q[0]);
        end
        void'(q.pop_front());
      end
      @(negedge clk);
      budget++;
    end
    tests_run++;
    if (q.size() != 0) begin
      tests_failed++;
      $display("FAIL rand_drain_timeout: got %0d beats outstanding expected 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
